// File: rtl/snake_mover.sv
// snake_mover: grid snake engine. Advances the snake one cell per game step,
// keeps the body in a segment shift register, and flags food, wall and self
// collisions. A combinational probe port lets the renderer ask whether a cell
// is occupied by the body.
module snake_mover #(
  parameter int unsigned GRID_W   = 8,
  parameter int unsigned GRID_H   = 8,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   direction,
  input  logic [$clog2(GRID_W)-1:0]    food_x,
  input  logic [$clog2(GRID_H)-1:0]    food_y,
  input  logic [$clog2(GRID_W)-1:0]    query_x,
  input  logic [$clog2(GRID_H)-1:0]    query_y,
  output logic                         query_hit,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         ate,
  output logic                         game_over
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = $clog2(STEP_DIV);

  // Direction codes
  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirRight = 2'b11;

  // FSM states
  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StOver = 1'b1;

  // Input synchronizer
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] dir_s;

  // Game state
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [LW-1:0] len_q, len_d;
  logic          ate_q, ate_d;

  // Segment storage, index 0 is the head
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];

  // Step datapath
  logic          tick;
  logic [1:0]    next_dir;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          wall_hit;
  logic          eat;
  logic [LW-1:0] chk_len;
  logic          self_hit;
  logic          shift_en;

  // Two-flop synchronizer for the asynchronous direction code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= direction;
      sync2_q <= sync1_q;
    end
  end

  assign dir_s = sync2_q;

  // Game step strobe: last count of the divider while running
  assign tick = (state_q == StRun) && (cnt_q == CW'(STEP_DIV - 1));

  // Pick the new heading; a direct reversal would fold the snake onto itself
  always_comb begin
    next_dir = dir_s;
    if (dir_s == {dir_q[1], ~dir_q[0]}) begin
      next_dir = dir_q;
    end
  end

  // Candidate head and wall detection; no wrap-around, so edge moves are fatal
  always_comb begin
    cand_x   = seg_x_q[0];
    cand_y   = seg_y_q[0];
    wall_hit = 1'b0;
    unique case (next_dir)
      DirUp: begin
        wall_hit = (seg_y_q[0] == '0);
        cand_y   = seg_y_q[0] - YW'(1);
      end
      DirDown: begin
        wall_hit = (seg_y_q[0] == YW'(GRID_H - 1));
        cand_y   = seg_y_q[0] + YW'(1);
      end
      DirLeft: begin
        wall_hit = (seg_x_q[0] == '0);
        cand_x   = seg_x_q[0] - XW'(1);
      end
      DirRight: begin
        wall_hit = (seg_x_q[0] == XW'(GRID_W - 1));
        cand_x   = seg_x_q[0] + XW'(1);
      end
      default: begin
        wall_hit = 1'b0;
      end
    endcase
  end

  // Food detection at the candidate cell
  assign eat = (cand_x == food_x) && (cand_y == food_y);

  // Self collision; the tail cell is free unless the snake grows this step
  always_comb begin
    chk_len  = eat ? len_q : (len_q - LW'(1));
    self_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LW'(i) < chk_len) && (seg_x_q[i] == cand_x) && (seg_y_q[i] == cand_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Control next-state: divider, FSM, heading, length and eat pulse
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    len_d    = len_q;
    ate_d    = 1'b0;
    shift_en = 1'b0;
    if (state_q == StRun) begin
      cnt_d = tick ? '0 : (cnt_q + CW'(1));
      if (tick) begin
        if (wall_hit || self_hit) begin
          // Freeze the body exactly as it was before the fatal move
          state_d = StOver;
        end else begin
          shift_en = 1'b1;
          dir_d    = next_dir;
          ate_d    = eat;
          if (eat && (len_q != LW'(MAX_LEN))) begin
            len_d = len_q + LW'(1);
          end
        end
      end
    end
  end

  // Segment shift: every segment follows the one ahead, head takes the candidate
  always_comb begin
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    if (shift_en) begin
      seg_x_d[0] = cand_x;
      seg_y_d[0] = cand_y;
      for (int i = 1; i < int'(MAX_LEN); i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      dir_q   <= DirRight;
      len_q   <= LW'(3);
      ate_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      ate_q   <= ate_d;
    end
  end

  // Segment registers; reset lays a 3-long snake left of centre, heading right
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= (i < 3) ? XW'(int'(GRID_W / 2) - i) : '0;
        seg_y_q[i] <= (i < 3) ? YW'(GRID_H / 2) : '0;
      end
    end else begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  // Renderer probe: only live segments (index < length) can match
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LW'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        query_hit = 1'b1;
      end
    end
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign ate       = ate_q;
  assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: directed scenarios plus randomized play, every cycle compared
// against a queue-based behavioural model of the snake.
module tb_snake_mover;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int ML = 16;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] direction = 2'b11;
  logic [2:0] food_x = 3'd7, food_y = 3'd0;
  logic [2:0] query_x = 3'd0, query_y = 3'd0;
  logic       query_hit, ate, game_over;
  logic [2:0] head_x, head_y;
  logic [4:0] length;

  snake_mover #(
    .GRID_W  (W),
    .GRID_H  (H),
    .MAX_LEN (ML),
    .STEP_DIV(SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .direction(direction),
    .food_x   (food_x),
    .food_y   (food_y),
    .query_x  (query_x),
    .query_y  (query_y),
    .query_hit(query_hit),
    .head_x   (head_x),
    .head_y   (head_y),
    .length   (length),
    .ate      (ate),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Behavioural model: body as a queue of cells, head at the front
  int mb_x[$];
  int mb_y[$];
  int m_len, m_dir, m_cnt;
  bit m_over, m_ate;
  int m_sync[$];  // direction samples still in flight, oldest first
  int ate_count;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int dx(input int d);
    case (d)
      2: return -1;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy(input int d);
    case (d)
      0: return -1;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_query(input int qx, input int qy);
    for (int i = 0; i < m_len; i++) begin
      if (mb_x[i] == qx && mb_y[i] == qy) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    mb_x   = '{W / 2, W / 2 - 1, W / 2 - 2};
    mb_y   = '{H / 2, H / 2, H / 2};
    m_len  = 3;
    m_dir  = 3;
    m_cnt  = 0;
    m_over = 1'b0;
    m_ate  = 1'b0;
    m_sync = '{3, 3};
  endtask

  // One clock edge of the game rules, using inputs present at that edge
  task automatic model_step();
    int dir_s, nd, nx, ny, lim;
    bit eat, hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dir_s = m_sync[0];
    void'(m_sync.pop_front());
    m_sync.push_back(int'(direction));
    m_ate = 1'b0;
    if (m_over) return;
    if (m_cnt != SD - 1) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    nd  = (dir_s == opposite(m_dir)) ? m_dir : dir_s;
    nx  = mb_x[0] + dx(nd);
    ny  = mb_y[0] + dy(nd);
    eat = (nx == int'(food_x)) && (ny == int'(food_y));
    hit = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
    lim = eat ? m_len : m_len - 1;
    for (int i = 0; i < lim; i++) begin
      if (mb_x[i] == nx && mb_y[i] == ny) hit = 1'b1;
    end
    if (hit) begin
      m_over = 1'b1;
      return;
    end
    m_dir = nd;
    m_ate = eat;
    if (eat) ate_count++;
    mb_x.push_front(nx);
    mb_y.push_front(ny);
    if (eat && m_len < ML) begin
      m_len++;
    end else begin
      void'(mb_x.pop_back());
      void'(mb_y.pop_back());
    end
  endtask

  task automatic check_all();
    check_eq("head_x", int'(head_x), mb_x[0]);
    check_eq("head_y", int'(head_y), mb_y[0]);
    check_eq("length", int'(length), m_len);
    check_eq("ate", int'(ate), int'(m_ate));
    check_eq("game_over", int'(game_over), int'(m_over));
    check_eq("query_hit", int'(query_hit), int'(model_query(int'(query_x), int'(query_y))));
  endtask

  // Drive at the falling edge, check, then let one rising edge happen
  task automatic cycle(input bit rst, input int d, input int fx, input int fy,
                       input int qx, input int qy);
    rst_n     = rst;
    direction = 2'(d);
    food_x    = 3'(fx);
    food_y    = 3'(fy);
    query_x   = 3'(qx);
    query_y   = 3'(qy);
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic steps(input int n, input int d, input int fx, input int fy);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, d, fx, fy, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 3, 7, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cur_d, fx, fy, ax, ay;
    bit r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset release and first step
    steps(3, 3, 7, 0);
    check_eq("rst_head_x", int'(head_x), 4);
    check_eq("rst_len", int'(length), 3);
    query_x = 3'd2;
    query_y = 3'd4;
    #1 check_eq("q24_before", int'(query_hit), 1);
    cycle(1'b1, 3, 7, 0, 2, 4);
    check_eq("first_tick_x", int'(head_x), 5);
    check_eq("q24_after", int'(query_hit), 0);

    // Reversal ignored, then turn up
    steps(4, 2, 7, 0);
    check_eq("rev_ignored_x", int'(head_x), 6);
    steps(4, 0, 7, 0);
    check_eq("turn_up_y", int'(head_y), 3);
    check_eq("turn_up_x", int'(head_x), 6);

    // Eat, then wall collision and freeze
    do_reset();
    steps(4, 3, 6, 4);
    steps(4, 3, 6, 4);
    check_eq("eat_pulse", int'(ate), 1);
    check_eq("eat_len", int'(length), 4);
    query_x = 3'd3;
    query_y = 3'd4;
    #1 check_eq("tail_kept", int'(query_hit), 1);
    steps(1, 3, 7, 0);
    check_eq("eat_one_cycle", int'(ate), 0);
    steps(3, 3, 7, 0);
    check_eq("at_edge_x", int'(head_x), 7);
    steps(4, 3, 7, 0);
    check_eq("wall_over", int'(game_over), 1);
    steps(20, 0, 7, 0);
    check_eq("frozen_x", int'(head_x), 7);
    check_eq("frozen_len", int'(length), 4);
    do_reset();
    check_eq("over_rst_x", int'(head_x), 4);
    check_eq("over_rst_go", int'(game_over), 0);

    // Self collision with a length-5 body
    steps(4, 3, 5, 4);
    steps(4, 3, 6, 4);
    check_eq("len5", int'(length), 5);
    steps(4, 0, 7, 0);
    steps(4, 2, 7, 0);
    steps(4, 1, 7, 0);
    check_eq("self_over", int'(game_over), 1);
    check_eq("self_head_x", int'(head_x), 5);

    // Moving into the vacating tail is legal
    do_reset();
    steps(4, 3, 5, 4);
    steps(4, 0, 7, 0);
    steps(4, 2, 7, 0);
    steps(4, 1, 7, 0);
    check_eq("tail_move_go", int'(game_over), 0);
    check_eq("tail_move_y", int'(head_y), 4);

    // Reset mid-step restarts the divider
    steps(2, 1, 7, 0);
    do_reset();
    check_eq("mid_rst_len", int'(length), 3);
    steps(3, 3, 7, 0);
    check_eq("mid_rst_hold", int'(head_x), 4);
    steps(1, 3, 7, 0);
    check_eq("mid_rst_tick", int'(head_x), 5);

    // Eat on every step along a clear path until past saturation
    do_reset();
    ate_count = 0;
    for (int t = 0; t < 16; t++) begin
      cur_d = (t < 3) ? 3 : (t < 7) ? 0 : (t < 14) ? 2 : 1;
      fx = mb_x[0] + dx(cur_d);
      fy = mb_y[0] + dy(cur_d);
      steps(4, cur_d, fx, fy);
    end
    check_eq("sat_len", int'(length), ML);
    check_eq("sat_ate", int'(ate), 1);
    check_eq("sat_eat_count", ate_count, 16);
    check_eq("sat_alive", int'(game_over), 0);

    // Randomized play
    cur_d = 3;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) cur_d = $urandom_range(0, 3);
      ax = mb_x[0] + dx(m_dir);
      ay = mb_y[0] + dy(m_dir);
      if ($urandom_range(0, 2) == 0 && ax >= 0 && ax < W && ay >= 0 && ay < H) begin
        fx = ax;
        fy = ay;
      end else begin
        fx = $urandom_range(0, W - 1);
        fy = $urandom_range(0, H - 1);
      end
      r = !((m_over && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0);
      cycle(r, cur_d, fx, fy, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_mover.md
Name: snake_mover

Overview:
- Consumes the 2-bit direction code from the keypad direction stage and advances the snake one grid cell per game step.
- Holds the snake body in a segment shift register and detects food, wall and self collision.
- Exposes head position, length, an eat pulse, a game-over flag and a body-occupancy query port for the display scanner.
- Sits between the direction stage and the VGA/LED-matrix renderer; the food generator also reads `ate`.

Parameters:
- GRID_W, 8, grid width in cells; x range 0..GRID_W-1.
- GRID_H, 8, grid height in cells; y range 0..GRID_H-1.
- MAX_LEN, 16, segment storage depth and maximum snake length (>=4).
- STEP_DIV, 4, clk cycles per game step (>=2). Use 4 in simulation and about 12_500_000 on board.
- XW/YW (local), clog2(GRID_W) and clog2(GRID_H). LW (local) = clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- direction  in  2  00 up, 01 down, 10 left, 11 right; asynchronous to clk.
- food_x  in  XW  food cell x.
- food_y  in  YW  food cell y.
- query_x  in  XW  renderer probe x.
- query_y  in  YW  renderer probe y.
- query_hit  out  1  combinational; 1 if (query_x,query_y) equals any segment index < length.
- head_x  out  XW  registered head x (segment 0).
- head_y  out  YW  registered head y.
- length  out  LW  current segment count.
- ate  out  1  one-cycle pulse on the step where food is eaten.
- game_over  out  1  sticky collision flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rst_n, sampled at the posedge.
- Reset values:
  - seg[0]=(GRID_W/2, GRID_H/2), seg[1]=(GRID_W/2-1, GRID_H/2), seg[2]=(GRID_W/2-2, GRID_H/2); other segments 0.
  - length=3, cur_dir=11 (right), step counter=0, ate=0, game_over=0, state=RUN.
  - Synchronizer flops reset to 11.
- Reset asserted mid-game or in OVER returns everything to the reset values on that edge.
- Input sync: direction passes through a 2-flop synchronizer (2-cycle latency). Only the synchronized value (dir_s) is used.
- Step counter: counts 0..STEP_DIV-1 in RUN, then wraps. tick=1 when the counter equals STEP_DIV-1. The counter holds in OVER.
- FSM RUN:
  - On tick, next_dir = dir_s unless dir_s is the reverse of cur_dir (00<->01, 10<->11). If it is the reverse, next_dir = cur_dir.
  - cur_dir <= next_dir.
  - Candidate head: up y-1, down y+1, left x-1, right x+1.
- Wall check: the move is a wall hit if y==0 and up, y==GRID_H-1 and down, x==0 and left, or x==GRID_W-1 and right. No wrap-around.
- Eat check: eat = (candidate == (food_x, food_y)).
- Self check:
  - Compare the candidate against seg[0..length-2] when eat=0 (the tail vacates this step).
  - Compare against seg[0..length-1] when eat=1.
- Wall or self hit: game_over<=1, go to OVER. Segments, length and cur_dir stay unchanged; ate stays 0.
- Otherwise: seg[i]<=seg[i-1] for i>=1, seg[0]<=candidate.
- If eat: ate<=1 for that cycle. length<=length+1, saturating at MAX_LEN; at saturation no growth, but ate still pulses.
- Outputs are registered and update on the tick edge. head_x/head_y reflect the new head the cycle after the tick.
- FSM OVER: all state frozen, game_over=1, ate=0. Only rst_n exits.
- query_hit is purely combinational over seg[0..length-1]. Segments at index >= length never match.
- Direction changes between ticks: only the dir_s value present on the tick cycle matters.

Test Plan (GRID 8x8, MAX_LEN 16, STEP_DIV 4, food parked at (7,0) unless stated):
- Reset release, direction=11 held → head (4,4), length 3; first tick at the 4th clk moves head to (5,4); query (2,4)=1 before the step and 0 after.
- Drive direction=10 (reverse of right) → ignored, head goes (5,4)→(6,4); drive 00 → head (6,3) on the next tick after 2-cycle sync.
- Food at (6,4), snake heading right from (5,4) → on that tick ate=1 for exactly one cycle, length 3→4, tail (3,4) still occupied.
- Head at (7,4) moving right → next tick sets game_over=1; head stays (7,4); step counter and segments freeze for 20 further cycles.
- Length 5, drive the sequence up, left, down so the candidate equals seg[3] → game_over=1. Separately, the candidate equal to the vacating tail with eat=0 → legal move, no game_over.
- Assert rst_n=0 for one cycle while in OVER, and again mid-step → next edge restores head (4,4), length 3, game_over=0, counter 0.
